// File: rtl/rr_arbiter_onehot.sv
// 8-way round-robin arbiter with registered one-hot grant held until done.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_onehot #(
  parameter int N       = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] idx_n, pick;
  logic [N-1:0]     gnt_n;
  logic             found;
  logic             expire;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[ptr + IDX_W'(i)]) begin
        found = 1'b1;
        pick  = ptr + IDX_W'(i);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wdog;

  assign expire = ~done & (wdog == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= (state == GRANT) & expire;
      wdog    <= (state == GRANT) ? wdog + 8'd1 : '0;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    idx_n   = gnt_idx;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          gnt_n   = N'(1) << pick;
          idx_n   = pick;
        end
      end
      GRANT: begin
        if (done || expire) begin
          state_n = IDLE;
          gnt_n   = '0;
          idx_n   = '0;
          ptr_n   = gnt_idx + IDX_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gnt     <= gnt_n;
      gnt_idx <= idx_n;
    end
  end

  assign gnt_valid = |gnt;

endmodule
